// File: rtl/partition_err_monitor_if.sv
// Vector handshake bus between the partition response source and the error monitor.
// Carries the stimulus index and both partition outputs for one vector.
interface partition_err_monitor_if #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 6
) ();
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_idx;
    logic [OUT_W-1:0] approx_po;
    logic [OUT_W-1:0] exact_po;

    modport master (output in_valid, in_idx, approx_po, exact_po, input in_ready);
    modport slave  (input in_valid, in_idx, approx_po, exact_po, output in_ready);
endinterface

// File: rtl/partition_err_monitor.sv
// Sweeps 2^IN_W response vectors and accumulates mismatch count, Hamming-distance
// sum and maximum absolute error between the approximate and exact partitions.
module partition_err_monitor #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    partition_err_monitor_if.slave          bus,
    output logic                            busy,
    output logic                            done,
    output logic [IN_W:0]                   err_count,
    output logic [IN_W+$clog2(OUT_W+1)-1:0] hd_sum,
    output logic [OUT_W-1:0]                max_abs_err,
    output logic                            seq_error
);
    localparam int unsigned PC_W  = $clog2(OUT_W + 1);
    localparam int unsigned ERR_W = IN_W + 1;
    localparam int unsigned HD_W  = IN_W + PC_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             w_in_ready;
    logic             w_busy;
    logic             w_done;
    logic             w_hs;
    logic             w_start_ok;
    logic             w_last;
    logic             w_mis;
    logic [OUT_W-1:0] w_xor;
    logic [OUT_W-1:0] w_absdiff;
    logic [PC_W-1:0]  w_pop;

    logic [IN_W-1:0]  r_exp_idx;
    logic             r_s1_valid;
    logic             r_s1_mis;
    logic [PC_W-1:0]  r_s1_pop;
    logic [OUT_W-1:0] r_s1_abs;
    logic [ERR_W-1:0] r_err_count;
    logic [HD_W-1:0]  r_hd_sum;
    logic [OUT_W-1:0] r_max_abs;
    logic             r_seq_error;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // DRAIN waits for the last vector to leave stage 1; that edge is the final accumulation.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)      w_state_nxt = S_RUN;
            S_RUN:   if (w_last)     w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_s1_valid) w_state_nxt = S_DONE;
            S_DONE:  if (start)      w_state_nxt = S_RUN;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_RUN:   begin w_in_ready = 1'b1; w_busy = 1'b1; end
            S_DRAIN: w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_hs       = bus.in_valid & w_in_ready;
    assign w_last     = w_hs & (r_exp_idx == {IN_W{1'b1}});
    assign w_xor      = bus.approx_po ^ bus.exact_po;
    assign w_mis      = |w_xor;
    assign w_absdiff  = (bus.approx_po >= bus.exact_po) ? (bus.approx_po - bus.exact_po)
                                                        : (bus.exact_po - bus.approx_po);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < OUT_W; i++) w_pop = w_pop + PC_W'(w_xor[i]);
    end

    // Stage 1 captures per-vector metrics on the handshake; stage 2 folds them in.
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_exp_idx   <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_mis    <= 1'b0;
            r_s1_pop    <= '0;
            r_s1_abs    <= '0;
            r_err_count <= '0;
            r_hd_sum    <= '0;
            r_max_abs   <= '0;
            r_seq_error <= 1'b0;
        end else begin
            r_s1_valid <= w_hs;
            if (w_hs) begin
                r_s1_mis  <= w_mis;
                r_s1_pop  <= w_pop;
                r_s1_abs  <= w_absdiff;
                r_exp_idx <= r_exp_idx + IN_W'(1);
                if (bus.in_idx != r_exp_idx) r_seq_error <= 1'b1;
            end
            if (r_s1_valid) begin
                r_err_count <= r_err_count + ERR_W'(r_s1_mis);
                r_hd_sum    <= r_hd_sum + HD_W'(r_s1_pop);
                if (r_s1_abs > r_max_abs) r_max_abs <= r_s1_abs;
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign busy         = w_busy;
    assign done         = w_done;
    assign err_count    = r_err_count;
    assign hd_sum       = r_hd_sum;
    assign max_abs_err  = r_max_abs;
    assign seq_error    = r_seq_error;
endmodule

// File: tb/tb_partition_err_monitor.sv
// Directed bench for partition_err_monitor: table of full-sweep runs plus
// hand-written reset/timing sequences, all with hand-computed expectations.
module tb_partition_err_monitor;
    localparam int unsigned IN_W  = 8;
    localparam int unsigned OUT_W = 6;
    localparam int          N_VEC = 256;
    localparam int          N_RUN = 7;

    typedef struct {
        int fault_idx;   // expected index carrying the fault data, -1 for none
        int a_fault;
        int e_fault;
        int a_def;
        int e_def;
        int bad_hs;      // handshake number presenting in_idx=3, -1 for none
        int bubbles;
        int mid_start;
        int exp_err;
        int exp_hd;
        int exp_max;
        int exp_seq;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic [IN_W:0] err_count;
    logic [IN_W+$clog2(OUT_W+1)-1:0] hd_sum;
    logic [OUT_W-1:0] max_abs_err;
    logic seq_error;

    int    n_tests = 0;
    int    n_fail  = 0;
    string cur_tag = "init";
    vec_t  vecs[N_RUN];

    partition_err_monitor_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    partition_err_monitor #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err_count  (err_count),
        .hd_sum     (hd_sum),
        .max_abs_err(max_abs_err),
        .seq_error  (seq_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d", cur_tag, name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int hs;
        int cyc;
        bit took;
        int held_err;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hs  = 0;
        cyc = 0;
        while (hs < N_VEC && cyc < 4 * N_VEC) begin
            bus.in_valid  = (v.bubbles != 0) ? ($urandom_range(1, 0) == 1) : 1'b1;
            start         = (v.mid_start != 0) && (cyc == 60);
            bus.in_idx    = IN_W'((hs == v.bad_hs) ? 3 : hs);
            bus.approx_po = OUT_W'((hs == v.fault_idx) ? v.a_fault : v.a_def);
            bus.exact_po  = OUT_W'((hs == v.fault_idx) ? v.e_fault : v.e_def);
            took = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (took) hs++;
            cyc++;
        end
        start        = 1'b0;
        bus.in_valid = 1'b0;
        chk("handshakes", hs, N_VEC);
        // One cycle after the last handshake edge: draining
        chk("drain_ready", int'(bus.in_ready), 0);
        chk("drain_busy",  int'(busy), 1);
        chk("drain_done",  int'(done), 0);
        @(posedge clk); #1;
        chk("done",        int'(done), 1);
        chk("done_busy",   int'(busy), 0);
        chk("err_count",   int'(err_count), v.exp_err);
        chk("hd_sum",      int'(hd_sum), v.exp_hd);
        chk("max_abs_err", int'(max_abs_err), v.exp_max);
        chk("seq_error",   int'(seq_error), v.exp_seq);
        held_err = int'(err_count);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_done", int'(done), 1);
        chk("hold_err",  int'(err_count), v.exp_err);
        chk("hold_hd",   int'(hd_sum), v.exp_hd);
        if (held_err != v.exp_err) chk("hold_err_stable", int'(err_count), held_err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           fidx  af     ef     ad     ed     bad bub mid  err  hd    max seq
        vecs[0] = '{-1,   0,     0,     'h15,  'h15,  -1, 0,  0,   0,   0,    0,  0};
        vecs[1] = '{5,    'h07,  'h00,  0,     0,     -1, 0,  0,   1,   3,    7,  0};
        vecs[2] = '{-1,   0,     0,     'h3F,  'h00,  -1, 0,  0,   256, 1536, 63, 0};
        vecs[3] = '{-1,   0,     0,     'h2A,  'h2A,  2,  0,  0,   0,   0,    0,  1};
        vecs[4] = '{5,    'h07,  'h00,  0,     0,     -1, 1,  1,   1,   3,    7,  0};
        vecs[5] = '{200,  'h00,  'h2A,  'h11,  'h11,  -1, 1,  0,   1,   3,    42, 0};
        vecs[6] = '{-1,   0,     0,     'h01,  'h02,  -1, 0,  0,   256, 512,  1,  0};

        rst           = 1'b1;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_idx    = '0;
        bus.approx_po = '0;
        bus.exact_po  = '0;
        repeat (3) @(posedge clk);
        #1;
        cur_tag = "reset";
        chk("in_ready",    int'(bus.in_ready), 0);
        chk("busy",        int'(busy), 0);
        chk("done",        int'(done), 0);
        chk("err_count",   int'(err_count), 0);
        chk("hd_sum",      int'(hd_sum), 0);
        chk("max_abs_err", int'(max_abs_err), 0);
        chk("seq_error",   int'(seq_error), 0);
        rst = 1'b0;
        bus.in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        cur_tag = "idle_wait";
        chk("busy",     int'(busy), 0);
        chk("in_ready", int'(bus.in_ready), 0);
        bus.in_valid = 1'b0;

        for (int r = 0; r < N_RUN; r++) begin
            cur_tag = $sformatf("run%0d", r);
            run_vec(vecs[r]);
        end

        // Reset in the middle of a run after handshake 100
        cur_tag = "mid_rst";
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k <= 100; k++) begin
            bus.in_valid  = 1'b1;
            bus.in_idx    = IN_W'(k);
            bus.approx_po = OUT_W'('h3F);
            bus.exact_po  = OUT_W'(0);
            @(posedge clk); #1;
        end
        chk("pre_rst_err", int'(err_count), 100);
        rst = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("in_ready",    int'(bus.in_ready), 0);
        chk("busy",        int'(busy), 0);
        chk("done",        int'(done), 0);
        chk("err_count",   int'(err_count), 0);
        chk("hd_sum",      int'(hd_sum), 0);
        chk("max_abs_err", int'(max_abs_err), 0);
        chk("seq_error",   int'(seq_error), 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after", int'(busy), 0);
        cur_tag = "post_rst";
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
